// File: rtl/conv_sysarr_div_pkg.sv
// Shared definitions for the conv systolic-array sequential divider.
// Holds the default operand widths, the quotient saturation constants
// used for divide-by-zero, and the divider FSM state encoding.
package conv_sysarr_div_pkg;

  localparam int DIN0_W = 11;
  localparam int DIN1_W = 8;
  localparam int DOUT_W = 11;

  // Saturation values for a DOUT_W-bit signed quotient: 1023 and -1024 at defaults.
  localparam logic [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_t;

endpackage

// File: rtl/conv_sysarr_div_step.sv
// One restoring-division step, purely combinational.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
// Ports:
//   remAcc_i  - partial remainder before this step (always < divisor)
//   divisor_i - unsigned divisor
//   nextBit_i - next dividend bit, MSB first
//   remAcc_o  - partial remainder after this step
//   qBit_o    - quotient bit produced by this step
module conv_sysarr_div_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] remAcc_i,
  input  logic [DW-1:0] divisor_i,
  input  logic          nextBit_i,
  output logic [DW-1:0] remAcc_o,
  output logic          qBit_o
);

  logic [DW:0] trial;

  // The trial value needs one extra bit; once the divisor has been
  // subtracted the result is below the divisor again and fits in DW bits.
  always_comb begin
    trial = {remAcc_i, nextBit_i};
    if (trial >= {1'b0, divisor_i}) begin
      qBit_o   = 1'b1;
      remAcc_o = DW'(trial - {1'b0, divisor_i});
    end else begin
      qBit_o   = 1'b0;
      remAcc_o = trial[DW-1:0];
    end
  end

endmodule

// File: rtl/conv_sysarr_dbbuf_div_seq_11s_8ns.sv
// Sequential signed-by-unsigned divider (11-bit signed / 8-bit unsigned).
// Restoring algorithm, one quotient bit per enabled clock, with valid/ready
// handshakes on input and output and a global clock enable that stalls all state.
// The quotient is truncated toward zero and the remainder takes the dividend's sign.
// A zero divisor flags div_zero and saturates the quotient with the same latency.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   ce                  - clock enable, 0 freezes every register
//   in_valid/in_ready   - operand handshake, in_ready only while idle
//   din0, din1          - signed dividend, unsigned divisor
//   out_valid/out_ready - result handshake
//   dout, rem, div_zero - quotient, remainder, divide-by-zero flag
module conv_sysarr_dbbuf_div_seq_11s_8ns
  import conv_sysarr_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  div_zero
);

  localparam int N     = din0_WIDTH;
  localparam int DW    = din1_WIDTH;
  localparam int RW    = din1_WIDTH + 1;
  localparam int CNT_W = $clog2(N + 1);

  divState_t        state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             neg_q,      neg_d;
  logic [N-1:0]     dvd_q,      dvd_d;
  logic [N-1:0]     quo_q,      quo_d;
  logic [DW-1:0]    remAcc_q,   remAcc_d;
  logic [DW-1:0]    divisor_q,  divisor_d;
  logic             outValid_q, outValid_d;
  logic [N-1:0]     dout_q,     dout_d;
  logic [RW-1:0]    rem_q,      rem_d;
  logic             divZero_q,  divZero_d;

  logic [DW-1:0]    stepRem;
  logic             stepBit;
  logic [RW-1:0]    remMag;
  logic             unusedParams;

  // ID and NUM_STAGE only exist so generated instantiations keep working.
  assign unusedParams = ^{ID, NUM_STAGE};

  // A single step instance is reused on every CALC cycle; the dividend
  // register shifts left so its MSB is always the next bit to bring down.
  conv_sysarr_div_step #(
    .DW (DW)
  ) uStep (
    .remAcc_i  (remAcc_q),
    .divisor_i (divisor_q),
    .nextBit_i (dvd_q[N-1]),
    .remAcc_o  (stepRem),
    .qBit_o    (stepBit)
  );

  assign remMag    = {1'b0, remAcc_q};
  assign in_ready  = (state_q == IDLE) & ~reset;
  assign out_valid = outValid_q;
  assign dout      = dout_q;
  assign rem       = rem_q;
  assign div_zero  = divZero_q;

  // Next-state and datapath logic. Everything defaults to holding its value,
  // so only the fields touched in each state are assigned. The dividend is
  // stored as a magnitude; -2^(N-1) becomes 2^(N-1), which still fits in N
  // unsigned bits. Sign correction happens once, in FIX.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    remAcc_d   = remAcc_q;
    divisor_d  = divisor_q;
    outValid_d = outValid_q;
    dout_d     = dout_q;
    rem_d      = rem_q;
    divZero_d  = divZero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_d     = din0[N-1];
          dvd_d     = din0[N-1] ? (~din0 + N'(1)) : din0;
          divisor_d = din1;
          quo_d     = '0;
          remAcc_d  = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        dvd_d    = {dvd_q[N-2:0], 1'b0};
        quo_d    = {quo_q[N-2:0], stepBit};
        remAcc_d = stepRem;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (divisor_q == '0) begin
          divZero_d = 1'b1;
          rem_d     = '0;
          dout_d    = neg_q ? N'(QMIN) : N'(QMAX);
        end else begin
          divZero_d = 1'b0;
          rem_d     = neg_q ? (~remMag + RW'(1)) : remMag;
          dout_d    = neg_q ? (~quo_q + N'(1)) : quo_q;
        end
        outValid_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset wins over ce; otherwise nothing moves unless ce is
  // high, which makes a stall invisible apart from the added delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      dvd_q      <= '0;
      quo_q      <= '0;
      remAcc_q   <= '0;
      divisor_q  <= '0;
      outValid_q <= 1'b0;
      dout_q     <= '0;
      rem_q      <= '0;
      divZero_q  <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      remAcc_q   <= remAcc_d;
      divisor_q  <= divisor_d;
      outValid_q <= outValid_d;
      dout_q     <= dout_d;
      rem_q      <= rem_d;
      divZero_q  <= divZero_d;
    end
  end

endmodule

// File: tb/tb_conv_sysarr_dbbuf_div_seq_11s_8ns.sv
// Directed testbench for the sequential 11s / 8ns divider.
// Each scenario task drives its own stimulus and compares against
// hand-computed quotient, remainder, flag and latency values.
module tb_conv_sysarr_dbbuf_div_seq_11s_8ns;

  logic               clk;
  logic               reset;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic [10:0]        din0;
  logic [7:0]         din1;
  logic               out_valid;
  logic               out_ready;
  logic signed [10:0] dout;
  logic signed [8:0]  rem;
  logic               div_zero;

  int testsRun;
  int failCount;

  conv_sysarr_dbbuf_div_seq_11s_8ns #(
    .ID         (1),
    .NUM_STAGE  (1),
    .din0_WIDTH (11),
    .din1_WIDTH (8),
    .dout_WIDTH (11)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  // 10 ns clock; inputs change and outputs are sampled 1 ns after each rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full operation with ce held high and pops the result.
  // lat counts rising edges from the accepting edge until out_valid is seen.
  task automatic doOp(input int a, input int b, output int lat,
                      output logic signed [10:0] q, output logic signed [8:0] r,
                      output logic z);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    din0     = 11'(a);
    din1     = 8'(b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    q = dout;
    r = rem;
    z = div_zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    tick();
    tick();
    testsRun++;
    if (in_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_in_ready_low: got %b expected 0", in_ready);
    end
    reset = 1'b0;
    #1;
    testsRun++;
    if (out_valid !== 1'b0 || dout !== 11'sd0 || rem !== 9'sd0 || div_zero !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got valid=%b dout=%0d rem=%0d dz=%b expected 0 0 0 0",
               out_valid, dout, rem, div_zero);
    end
    testsRun++;
    if (in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_in_ready_high: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic signed [10:0] q;
    logic signed [8:0] r;
    logic z;
    doOp(100, 7, lat, q, r, z);
    testsRun++;
    if (lat !== 12) begin
      failCount++;
      $display("[TB] FAIL basic_latency: got %0d expected 12", lat);
    end
    testsRun++;
    if (q !== 11'sd14 || r !== 9'sd2 || z !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_100_div_7: got q=%0d r=%0d dz=%b expected 14 2 0", q, r, z);
    end
    testsRun++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_after_pop: got in_ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_signs();
    int vecA [10] = '{-100, -1024, 1023, 0, 7, -7, 1000, -1000, -1, 1023};
    int vecB [10] = '{7, 1, 255, 5, 100, 100, 3, 3, 255, 1};
    int expQ [10] = '{-14, -1024, 4, 0, 0, 0, 333, -333, 0, 1023};
    int expR [10] = '{-2, 0, 3, 0, 7, -7, 1, -1, -1, 0};
    int lat;
    logic signed [10:0] q;
    logic signed [8:0] r;
    logic z;
    for (int i = 0; i < 10; i++) begin
      doOp(vecA[i], vecB[i], lat, q, r, z);
      testsRun++;
      if (q !== 11'(expQ[i]) || r !== 9'(expR[i]) || z !== 1'b0 || lat !== 12) begin
        failCount++;
        $display("[TB] FAIL signs_%0d_div_%0d: got q=%0d r=%0d dz=%b lat=%0d expected %0d %0d 0 12",
                 vecA[i], vecB[i], q, r, z, lat, expQ[i], expR[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic signed [10:0] q;
    logic signed [8:0] r;
    logic z;
    doOp(5, 0, lat, q, r, z);
    testsRun++;
    if (q !== 11'sd1023 || r !== 9'sd0 || z !== 1'b1 || lat !== 12) begin
      failCount++;
      $display("[TB] FAIL divzero_pos: got q=%0d r=%0d dz=%b lat=%0d expected 1023 0 1 12", q, r, z, lat);
    end
    doOp(-5, 0, lat, q, r, z);
    testsRun++;
    if (q !== -11'sd1024 || r !== 9'sd0 || z !== 1'b1 || lat !== 12) begin
      failCount++;
      $display("[TB] FAIL divzero_neg: got q=%0d r=%0d dz=%b lat=%0d expected -1024 0 1 12", q, r, z, lat);
    end
    doOp(0, 0, lat, q, r, z);
    testsRun++;
    if (q !== 11'sd1023 || r !== 9'sd0 || z !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL divzero_zero: got q=%0d r=%0d dz=%b expected 1023 0 1", q, r, z);
    end
    doOp(9, 3, lat, q, r, z);
    testsRun++;
    if (z !== 1'b0 || q !== 11'sd3) begin
      failCount++;
      $display("[TB] FAIL divzero_flag_clears: got q=%0d dz=%b expected 3 0", q, z);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit unstable;
    bit readySeen;
    bit validDropped;
    din0     = 11'd100;
    din1     = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    testsRun++;
    if (lat !== 12) begin
      failCount++;
      $display("[TB] FAIL bp_latency: got %0d expected 12", lat);
    end
    unstable     = 1'b0;
    readySeen    = 1'b0;
    validDropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dout !== 11'sd14 || rem !== 9'sd2 || div_zero !== 1'b0) unstable = 1'b1;
      if (in_ready !== 1'b0) readySeen = 1'b1;
      if (out_valid !== 1'b1) validDropped = 1'b1;
    end
    testsRun++;
    if (unstable || validDropped) begin
      failCount++;
      $display("[TB] FAIL bp_hold: got unstable=%b dropped=%b expected 0 0", unstable, validDropped);
    end
    testsRun++;
    if (readySeen) begin
      failCount++;
      $display("[TB] FAIL bp_in_ready: got in_ready high while holding expected 0");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    testsRun++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL bp_release: got in_ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ce_stall();
    int edges;
    bit earlyValid;
    bit readyDuringStall;
    bit lateValid;
    din0     = 11'd100;
    din1     = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    edges = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      edges++;
    end
    ce = 1'b0;
    earlyValid       = 1'b0;
    readyDuringStall = 1'b0;
    din0 = 11'd9;
    din1 = 8'd3;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      tick();
      edges++;
      if (out_valid !== 1'b0) earlyValid = 1'b1;
      if (in_ready !== 1'b0) readyDuringStall = 1'b1;
    end
    in_valid = 1'b0;
    ce = 1'b1;
    while (out_valid !== 1'b1 && edges < 60) begin
      tick();
      edges++;
    end
    testsRun++;
    if (edges !== 17 || earlyValid || readyDuringStall) begin
      failCount++;
      $display("[TB] FAIL ce_stall_latency: got edges=%0d early=%b ready=%b expected 17 0 0",
               edges, earlyValid, readyDuringStall);
    end
    testsRun++;
    if (dout !== 11'sd14 || rem !== 9'sd2 || div_zero !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ce_stall_result: got q=%0d r=%0d dz=%b expected 14 2 0", dout, rem, div_zero);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    lateValid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0) lateValid = 1'b1;
    end
    testsRun++;
    if (lateValid || in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ce_stall_pulse_ignored: got extra_valid=%b in_ready=%b expected 0 1",
               lateValid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic signed [10:0] q;
    logic signed [8:0] r;
    logic z;
    bit ghost;
    din0     = 11'd50;
    din1     = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    testsRun++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_mid_idle: got in_ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    ghost = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0) ghost = 1'b1;
    end
    testsRun++;
    if (ghost) begin
      failCount++;
      $display("[TB] FAIL reset_mid_no_result: got out_valid=1 after abort expected 0");
    end
    doOp(9, 3, lat, q, r, z);
    testsRun++;
    if (q !== 11'sd3 || r !== 9'sd0 || z !== 1'b0 || lat !== 12) begin
      failCount++;
      $display("[TB] FAIL reset_mid_next_op: got q=%0d r=%0d dz=%b lat=%0d expected 3 0 0 12", q, r, z, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    logic signed [10:0] q1;
    logic signed [10:0] q2;
    logic signed [8:0] r1;
    logic signed [8:0] r2;
    logic z1;
    logic z2;
    doOp(-1023, 10, lat1, q1, r1, z1);
    doOp(255, 16, lat2, q2, r2, z2);
    testsRun++;
    if (q1 !== -11'sd102 || r1 !== -9'sd3 || z1 !== 1'b0 || lat1 !== 12) begin
      failCount++;
      $display("[TB] FAIL b2b_first: got q=%0d r=%0d dz=%b lat=%0d expected -102 -3 0 12", q1, r1, z1, lat1);
    end
    testsRun++;
    if (q2 !== 11'sd15 || r2 !== 9'sd15 || z2 !== 1'b0 || lat2 !== 12) begin
      failCount++;
      $display("[TB] FAIL b2b_second: got q=%0d r=%0d dz=%b lat=%0d expected 15 15 0 12", q2, r2, z2, lat2);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_backpressure();
    test_ce_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
